// File: rtl/sentinel_pkg.sv
// rtl/sentinel_pkg.sv - shared types, display codes and width helpers for the sequence lock
package sentinel_pkg;

   typedef enum logic [1:0] {
      ST_LOCKED   = 2'd0,
      ST_ENTRY    = 2'd1,
      ST_UNLOCKED = 2'd2,
      ST_LOCKOUT  = 2'd3
   } state_t;

   // Seven-segment glyphs, {dp,g,f,e,d,c,b,a}, active low
   localparam logic [7:0] SEG_LOCKED   = 8'hC7;
   localparam logic [7:0] SEG_ENTRY    = 8'h47;
   localparam logic [7:0] SEG_UNLOCKED = 8'hC1;
   localparam logic [7:0] SEG_LOCKOUT  = 8'h86;
   localparam logic [7:0] SEG_OFF      = 8'hFF;

   localparam int FAIL_W = 4;

   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int idx_width(input int len);
      return (len < 2) ? 1 : $clog2(len);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sentinel_seq_lock_if.sv
// rtl/sentinel_seq_lock_if.sv - keypad input and display/status output bundle of the lock
interface sentinel_seq_lock_if #(
   parameter int KEY_W = 8
);
   logic             ena;
   logic [KEY_W-1:0] key_in;
   logic             key_valid;
   logic             relock;
   logic [7:0]       seg_out;
   logic [7:0]       status;
   logic             unlocked;
   logic             alarm;
   logic [3:0]       fail_cnt;

   modport master (
      output ena, key_in, key_valid, relock,
      input  seg_out, status, unlocked, alarm, fail_cnt
   );

   modport slave (
      input  ena, key_in, key_valid, relock,
      output seg_out, status, unlocked, alarm, fail_cnt
   );
endinterface

// File: rtl/sentinel_timer.sv
// rtl/sentinel_timer.sv - loadable down-counter; expired_o is high during the last counted cycle
module sentinel_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expired_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A load of N makes the owner react exactly N edges after the load edge
   assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/sentinel_seq_lock.sv
// rtl/sentinel_seq_lock.sv - multi-digit key lock with entry timeout, failure lockout and auto-relock
module sentinel_seq_lock
   import sentinel_pkg::*;
#(
   parameter int                      KEY_W         = 8,
   parameter int                      KEY_LEN       = 4,
   parameter logic [KEY_LEN*KEY_W-1:0] KEY_SEQ      = 32'hB65AC30F,
   parameter int                      MAX_FAIL      = 3,
   parameter int                      LOCKOUT_CYC   = 1024,
   parameter int                      ENTRY_TIMEOUT = 256,
   parameter int                      UNLOCK_CYC    = 0
) (
   input  logic               clk,
   input  logic               rst,
   sentinel_seq_lock_if.slave io
);
   localparam int IDX_W = idx_width(KEY_LEN);
   localparam int TMR_W = cnt_width(max3(LOCKOUT_CYC, ENTRY_TIMEOUT, UNLOCK_CYC));
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(KEY_LEN - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               mism_q, mism_d;
   logic [FAIL_W-1:0]  fail_q, fail_d;
   logic [7:0]         seg_q, seg_d;
   logic [7:0]         status_q, status_d;
   logic               unlocked_q, unlocked_d;
   logic               alarm_q, alarm_d;

   logic               key_ok;
   logic [KEY_W-1:0]   exp_digit;
   logic               digit_miss;
   logic               finish;
   logic               fail_attempt;
   logic               entry_reload;
   logic               tmr_load;
   logic [TMR_W-1:0]   tmr_val;
   logic               tmr_exp;

   assign key_ok = io.ena & io.key_valid;

   always_comb begin
      exp_digit = '0;
      for (int i = 0; i < KEY_LEN; i++) begin
         if (idx_q == IDX_W'(i)) begin
            exp_digit = KEY_SEQ[(KEY_LEN-1-i)*KEY_W +: KEY_W];
         end
      end
   end

   // Mismatch accumulates so a wrong digit never shortens the attempt
   assign digit_miss = mism_q | (io.key_in != exp_digit);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      mism_d       = mism_q;
      fail_d       = fail_q;
      finish       = 1'b0;
      fail_attempt = 1'b0;
      entry_reload = 1'b0;

      case (state_q)
         ST_LOCKED: begin
            if (key_ok) begin
               if (KEY_LEN == 1) begin
                  finish       = 1'b1;
                  fail_attempt = digit_miss;
               end else begin
                  state_d = ST_ENTRY;
                  idx_d   = IDX_W'(1);
                  mism_d  = digit_miss;
               end
            end
         end
         ST_ENTRY: begin
            if (key_ok) begin
               if (idx_q == LAST_IDX) begin
                  finish       = 1'b1;
                  fail_attempt = digit_miss;
               end else begin
                  idx_d        = idx_q + IDX_W'(1);
                  mism_d       = digit_miss;
                  entry_reload = 1'b1;
               end
            end else if (tmr_exp) begin
               finish       = 1'b1;
               fail_attempt = 1'b1;
            end
         end
         ST_UNLOCKED: begin
            if (io.relock) begin
               state_d = ST_LOCKED;
            end else if ((UNLOCK_CYC > 0) && tmr_exp) begin
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKOUT: begin
            if (tmr_exp) begin
               state_d = ST_LOCKED;
               fail_d  = '0;
            end
         end
         default: state_d = ST_LOCKED;
      endcase

      if (finish) begin
         idx_d  = '0;
         mism_d = 1'b0;
         if (fail_attempt) begin
            fail_d  = (fail_q >= FAIL_MAX) ? fail_q : fail_q + FAIL_W'(1);
            state_d = (fail_d >= FAIL_MAX) ? ST_LOCKOUT : ST_LOCKED;
         end else begin
            fail_d  = '0;
            state_d = ST_UNLOCKED;
         end
      end
   end

   // One timer serves whichever timeout belongs to the state being entered
   always_comb begin
      tmr_load = (state_d != state_q) || entry_reload;
      case (state_d)
         ST_ENTRY:    tmr_val = TMR_W'(ENTRY_TIMEOUT);
         ST_LOCKOUT:  tmr_val = TMR_W'(LOCKOUT_CYC);
         ST_UNLOCKED: tmr_val = TMR_W'(UNLOCK_CYC);
         default:     tmr_val = '0;
      endcase
   end

   sentinel_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expired_o  (tmr_exp)
   );

   always_comb begin
      seg_d      = SEG_OFF;
      status_d   = 8'h00;
      unlocked_d = io.ena && (state_d == ST_UNLOCKED);
      alarm_d    = (state_d == ST_LOCKOUT);
      if (io.ena) begin
         case (state_d)
            ST_LOCKED:   seg_d = SEG_LOCKED;
            ST_ENTRY:    seg_d = SEG_ENTRY;
            ST_UNLOCKED: seg_d = SEG_UNLOCKED;
            default:     seg_d = SEG_LOCKOUT;
         endcase
         if (state_d == ST_UNLOCKED) begin
            status_d = 8'hFF;
         end else begin
            status_d = {alarm_d, (state_d == ST_ENTRY), 2'b00, fail_d};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_LOCKED;
         idx_q      <= '0;
         mism_q     <= 1'b0;
         fail_q     <= '0;
         seg_q      <= io.ena ? SEG_LOCKED : SEG_OFF;
         status_q   <= 8'h00;
         unlocked_q <= 1'b0;
         alarm_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         mism_q     <= mism_d;
         fail_q     <= fail_d;
         seg_q      <= seg_d;
         status_q   <= status_d;
         unlocked_q <= unlocked_d;
         alarm_q    <= alarm_d;
      end
   end

   assign io.seg_out  = seg_q;
   assign io.status   = status_q;
   assign io.unlocked = unlocked_q;
   assign io.alarm    = alarm_q;
   assign io.fail_cnt = fail_q;

endmodule

// File: tb/tb_sentinel_seq_lock.sv
// tb/tb_sentinel_seq_lock.sv - scoreboard bench for the sequence lock, default and auto-relock builds
module tb_sentinel_seq_lock;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sentinel_seq_lock_if #(.KEY_W(8)) b1 ();
   sentinel_seq_lock_if #(.KEY_W(8)) b2 ();

   sentinel_seq_lock u_dut (
      .clk (clk),
      .rst (rst),
      .io  (b1.slave)
   );

   sentinel_seq_lock #(.UNLOCK_CYC(16)) u_dut16 (
      .clk (clk),
      .rst (rst),
      .io  (b2.slave)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [21:0] exp_q[$];
   logic [21:0] got, want;
   logic [7:0]  good_key [0:3] = '{8'hB6, 8'h5A, 8'hC3, 8'h0F};

   function automatic logic [21:0] mk(input logic [7:0] s, input logic [7:0] st,
                                      input logic u, input logic a, input logic [3:0] f);
      return {s, st, u, a, f};
   endfunction

   function automatic logic [21:0] obs1();
      return {b1.seg_out, b1.status, b1.unlocked, b1.alarm, b1.fail_cnt};
   endfunction

   function automatic logic [21:0] obs2();
      return {b2.seg_out, b2.status, b2.unlocked, b2.alarm, b2.fail_cnt};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic e, input logic [7:0] k, input logic v, input logic r);
      b1.ena = e; b1.key_in = k; b1.key_valid = v; b1.relock = r;
      b2.ena = e; b2.key_in = k; b2.key_valid = v; b2.relock = r;
   endtask

   task automatic send(input logic [7:0] d);
      set_in(1'b1, d, 1'b1, 1'b0);
      tick();
      set_in(1'b1, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send(a);
      send(b);
      send(c);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b0, 8'h00, 1'b0, 1'b0);
      exp_q.push_back(mk(8'hFF, 8'h00, 1'b0, 1'b0, 4'd0));
      tick();
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL reset_ena0: got %h want %h", got, want); end
      set_in(1'b1, 8'h00, 1'b0, 1'b0);
      exp_q.push_back(mk(8'hC7, 8'h00, 1'b0, 1'b0, 4'd0));
      tick();
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL reset_ena1: got %h want %h", got, want); end
      rst = 1'b0;
   endtask

   task automatic test_unlock();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back((i == 3) ? mk(8'hC1, 8'hFF, 1'b1, 1'b0, 4'd0)
                                  : mk(8'h47, 8'h40, 1'b0, 1'b0, 4'd0));
         send(good_key[i]);
         want = exp_q.pop_front(); got = obs1(); n_chk++;
         if (got !== want) begin n_fail++; $display("FAIL unlock_digit%0d: got %h want %h", i, got, want); end
      end
      exp_q.push_back(mk(8'hC1, 8'hFF, 1'b1, 1'b0, 4'd0));
      for (int k = 0; k < 100; k++) tick();
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL unlock_hold: got %h want %h", got, want); end
      set_in(1'b1, 8'h00, 1'b0, 1'b1);
      exp_q.push_back(mk(8'hC7, 8'h00, 1'b0, 1'b0, 4'd0));
      tick();
      set_in(1'b1, 8'h00, 1'b0, 1'b0);
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL unlock_relock: got %h want %h", got, want); end
   endtask

   task automatic test_wrong();
      send(8'hB6);
      send(8'h00);
      exp_q.push_back(mk(8'h47, 8'h40, 1'b0, 1'b0, 4'd0));
      send(8'hC3);
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL wrong_pending: got %h want %h", got, want); end
      exp_q.push_back(mk(8'hC7, 8'h01, 1'b0, 1'b0, 4'd1));
      send(8'h0F);
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL wrong_verdict: got %h want %h", got, want); end
   endtask

   task automatic test_lockout();
      send3(8'h00, 8'h5A, 8'hC3);
      exp_q.push_back(mk(8'hC7, 8'h02, 1'b0, 1'b0, 4'd2));
      send(8'h0F);
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL lockout_fail2: got %h want %h", got, want); end
      send(8'hB6);
      send(8'h5A);
      exp_q.push_back(mk(8'h47, 8'h42, 1'b0, 1'b0, 4'd2));
      send(8'hC3);
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL lockout_entry: got %h want %h", got, want); end
      exp_q.push_back(mk(8'h86, 8'h83, 1'b0, 1'b1, 4'd3));
      send(8'h11);
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL lockout_enter: got %h want %h", got, want); end
      for (int k = 1; k <= 1024; k++) begin
         set_in(!(k >= 20 && k < 600), k[7:0], (k % 3) == 0, (k % 5) == 0);
         if (k == 10 || k == 1023) exp_q.push_back(mk(8'h86, 8'h83, 1'b0, 1'b1, 4'd3));
         if (k == 300)  exp_q.push_back(mk(8'hFF, 8'h00, 1'b0, 1'b1, 4'd3));
         if (k == 1024) exp_q.push_back(mk(8'hC7, 8'h00, 1'b0, 1'b0, 4'd0));
         tick();
         if (k == 10 || k == 300 || k == 1023 || k == 1024) begin
            want = exp_q.pop_front(); got = obs1(); n_chk++;
            if (got !== want) begin n_fail++; $display("FAIL lockout_cyc%0d: got %h want %h", k, got, want); end
         end
      end
      set_in(1'b1, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      send(8'hB6);
      send(8'h5A);
      for (int k = 1; k <= 256; k++) begin
         if (k == 255) exp_q.push_back(mk(8'h47, 8'h40, 1'b0, 1'b0, 4'd0));
         if (k == 256) exp_q.push_back(mk(8'hC7, 8'h01, 1'b0, 1'b0, 4'd1));
         tick();
         if (k >= 255) begin
            want = exp_q.pop_front(); got = obs1(); n_chk++;
            if (got !== want) begin n_fail++; $display("FAIL timeout_cyc%0d: got %h want %h", k, got, want); end
         end
      end
      send3(good_key[0], good_key[1], good_key[2]);
      exp_q.push_back(mk(8'hC1, 8'hFF, 1'b1, 1'b0, 4'd0));
      send(good_key[3]);
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL timeout_retry: got %h want %h", got, want); end
   endtask

   task automatic test_relock_priority();
      set_in(1'b1, 8'hB6, 1'b1, 1'b1);
      exp_q.push_back(mk(8'hC7, 8'h00, 1'b0, 1'b0, 4'd0));
      tick();
      set_in(1'b1, 8'h00, 1'b0, 1'b0);
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL relock_same_cycle: got %h want %h", got, want); end
      exp_q.push_back(mk(8'hC7, 8'h00, 1'b0, 1'b0, 4'd0));
      tick();
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL relock_key_dropped: got %h want %h", got, want); end
   endtask

   task automatic test_auto_relock();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      send3(good_key[0], good_key[1], good_key[2]);
      send(good_key[3]);
      for (int k = 1; k <= 20; k++) begin
         if (k == 15) exp_q.push_back(mk(8'hC1, 8'hFF, 1'b1, 1'b0, 4'd0));
         if (k == 16) exp_q.push_back(mk(8'hC7, 8'h00, 1'b0, 1'b0, 4'd0));
         tick();
         if (k == 15 || k == 16) begin
            want = exp_q.pop_front(); got = obs2(); n_chk++;
            if (got !== want) begin n_fail++; $display("FAIL auto_relock_cyc%0d: got %h want %h", k, got, want); end
         end
      end
      exp_q.push_back(mk(8'hC1, 8'hFF, 1'b1, 1'b0, 4'd0));
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL no_auto_relock: got %h want %h", got, want); end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      send3(8'h01, 8'h02, 8'h03);
      exp_q.push_back(mk(8'hC7, 8'h01, 1'b0, 1'b0, 4'd1));
      send(8'h04);
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL reset_mid_setup: got %h want %h", got, want); end
      send(8'h00);
      send(8'h00);
      rst = 1'b1;
      exp_q.push_back(mk(8'hC7, 8'h00, 1'b0, 1'b0, 4'd0));
      tick();
      rst = 1'b0;
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL reset_mid_entry: got %h want %h", got, want); end
      send3(good_key[0], good_key[1], good_key[2]);
      exp_q.push_back(mk(8'hC1, 8'hFF, 1'b1, 1'b0, 4'd0));
      send(good_key[3]);
      want = exp_q.pop_front(); got = obs1(); n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL reset_mid_clean: got %h want %h", got, want); end
   endtask

   initial begin
      test_reset();
      test_unlock();
      test_wrong();
      test_lockout();
      test_timeout();
      test_relock_priority();
      test_auto_relock();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sentinel_seq_lock.md
Name: sentinel_seq_lock

Overview:
Parametrised multi-digit successor to the single-byte Sentinel gate. Accepts a strobed sequence of KEY_LEN key digits and compares them against a hard-coded key. Tracks failed attempts and enforces a timed lockout after MAX_FAIL consecutive failures. Drives the 7-segment display and the status array from registered state.

Parameters:
KEY_W, 8, width of one key digit
KEY_LEN, 4, digits per attempt (1..16)
KEY_SEQ, 32'hB6_5A_C3_0F, packed key, KEY_LEN*KEY_W bits; digit 0 in the MSBs
MAX_FAIL, 3, consecutive failures that trigger lockout (1..15)
LOCKOUT_CYC, 1024, lockout duration in clk cycles (>=1)
ENTRY_TIMEOUT, 256, maximum idle cycles between digits during entry (>=1)
UNLOCK_CYC, 0, auto-relock delay in cycles; 0 = hold until relock

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ena  in  1  power-state enable
key_in  in  KEY_W  key digit
key_valid  in  1  one-cycle digit strobe; sampled only when ena=1
relock  in  1  return from UNLOCKED to LOCKED
seg_out  out  8  {dp,g,f,e,d,c,b,a}, active low
status  out  8  status array
unlocked  out  1  high in UNLOCKED
alarm  out  1  high in LOCKOUT
fail_cnt  out  4  consecutive failure count

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=LOCKED, digit index=0, mismatch flag=0, fail_cnt=0, timers=0, unlocked=0, alarm=0, seg_out=0xC7 if ena else 0xFF, status=0x00.
- States: LOCKED, ENTRY, UNLOCKED, LOCKOUT.
- LOCKED: key_valid compares the digit against digit 0, stores the mismatch, sets index=1, loads the entry timer, and goes to ENTRY. If KEY_LEN=1, it evaluates immediately instead.
- ENTRY: each key_valid compares key_in against digit[index], ORs the result into the mismatch flag, increments index, and reloads the timer.
- No early reject. All KEY_LEN digits are always consumed, so time-to-verdict does not depend on which digit was wrong.
- Verdict on the edge that captures the last digit:
  - Match: go to UNLOCKED, fail_cnt=0.
  - Mismatch: fail_cnt+1. If fail_cnt reaches MAX_FAIL, go to LOCKOUT and load LOCKOUT_CYC; otherwise go to LOCKED.
  - Index and mismatch flag clear on every exit from ENTRY.
- Entry timeout: if ENTRY_TIMEOUT cycles pass with no key_valid, the attempt counts as a failure with the same fail/lockout rules.
- UNLOCKED: key_valid is ignored. relock=1 goes to LOCKED. If UNLOCK_CYC>0, the state auto-returns to LOCKED after UNLOCK_CYC cycles. relock wins over a same-cycle key_valid or timer expiry.
- LOCKOUT: key_valid and relock are ignored and do not extend the timer. When the timer expires: go to LOCKED, fail_cnt=0.
- Latency: a state change is visible on the outputs on the edge that processes the input (1 cycle after the key_valid cycle).
- ena=0:
  - key_valid is ignored.
  - Timers keep running, so lockout cannot be bypassed by toggling ena.
  - seg_out=0xFF, status=0x00, unlocked=0.
  - alarm still reflects LOCKOUT.
- seg_out when ena=1:
  - LOCKED 0xC7 ('L')
  - ENTRY 0x47 ('L' with dp)
  - UNLOCKED 0xC1 ('U')
  - LOCKOUT 0x86 ('E')
- status: UNLOCKED gives 0xFF; otherwise {alarm, entry_active, 2'b00, fail_cnt}.
- fail_cnt saturates at MAX_FAIL and never wraps.
- Reset mid-entry or mid-lockout clears everything, including fail_cnt.

Decomposition:
- sentinel_pkg:
  - state enum
  - SEG_LOCKED, SEG_ENTRY, SEG_UNLOCKED, SEG_LOCKOUT, SEG_OFF constants
  - clog2-based helper width constants
- Sub-module sentinel_timer: a loadable down-counter with load, load value, and expired pulse, parametrised width. It is instanced once and shared, because only one of the entry, lockout, or unlock timeouts is active per state.

Test Plan:
- Reset, ena=1, enter B6,5A,C3,0F -> seg 0x47 after the first digit; 1 cycle after the 4th strobe: seg 0xC1, status 0xFF, unlocked=1, fail_cnt=0.
- Enter B6,00,C3,0F -> verdict at the same cycle as a correct entry; seg 0xC7, fail_cnt=1, status 0x01.
- Three wrong attempts -> alarm=1, seg 0x86, status 0x83. Keys during lockout are ignored. After 1024 cycles: seg 0xC7, fail_cnt=0.
- Two digits then 256 idle cycles -> ENTRY aborts to LOCKED with fail_cnt=1. A following full correct key unlocks.
- In UNLOCKED, relock and key_valid in the same cycle -> LOCKED, 0xC7, key dropped. With UNLOCK_CYC=16: auto-relock exactly 16 cycles after unlock.
- rst mid-entry -> all reset values next cycle. ena=0 during lockout -> seg 0xFF, and the lockout still expires on schedule.
